// File: rtl/product_accumulator_if.sv
// Product-beat input stream and completed-sum output stream of the product accumulator.
interface product_accumulator_if #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned PROD_W = 15;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              clr;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;

    modport master (
        output in_valid, in_product, in_last, clr, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_product, in_last, clr, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/product_accumulator.sv
// Saturating signed accumulator of multiplier products; holds each completed sum
// with its term count and sticky saturation flag until the consumer takes it.
module product_accumulator #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    product_accumulator_if.slave bus
);
    localparam int unsigned PROD_W = 15;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_OUT   = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sat, sat_nxt;

    logic             accept_c;
    logic [ACC_W-1:0] base_acc_c;
    logic [CNT_W-1:0] base_cnt_c;
    logic             base_sat_c;
    logic [SUM_W-1:0] wide_c;
    logic             ovf_c;

    // Operand selection: clr alongside a beat restarts the sum from that beat.
    always_comb begin
        accept_c   = bus.in_valid && (state == S_ACCUM);
        base_acc_c = bus.clr ? '0 : acc;
        base_cnt_c = bus.clr ? '0 : cnt;
        base_sat_c = bus.clr ? 1'b0 : sat;
        wide_c     = {base_acc_c[ACC_W-1], base_acc_c}
                   + {{(SUM_W-PROD_W){bus.in_product[PROD_W-1]}}, bus.in_product};
        ovf_c      = wide_c[SUM_W-1] ^ wide_c[SUM_W-2];
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        case (state)
            S_ACCUM: begin
                if (accept_c) begin
                    if (ovf_c)
                        acc_nxt = wide_c[SUM_W-1] ? ACC_MIN : ACC_MAX;
                    else
                        acc_nxt = wide_c[ACC_W-1:0];
                    cnt_nxt = (&base_cnt_c) ? base_cnt_c : base_cnt_c + CNT_W'(1);
                    sat_nxt = base_sat_c | ovf_c;
                    if (bus.in_last)
                        state_nxt = S_OUT;
                end else if (bus.clr) begin
                    acc_nxt = '0;
                    cnt_nxt = '0;
                    sat_nxt = 1'b0;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_nxt = S_ACCUM;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    sat_nxt   = 1'b0;
                end
            end
            default: state_nxt = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_ACCUM;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat_nxt;
        end
    end

    // Handshake flags decode the state flop only, so out_ready never reaches in_ready.
    assign bus.in_ready  = (state == S_ACCUM);
    assign bus.out_valid = (state == S_OUT);
    assign bus.out_sum   = acc;
    assign bus.out_count = cnt;
    assign bus.out_sat   = sat;
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed scenarios plus randomized traffic
// compared cycle by cycle against an integer-arithmetic model.
module tb_product_accumulator;
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 4;
    localparam int MAXV = (2 ** (AW - 1)) - 1;
    localparam int MINV = -(2 ** (AW - 1));
    localparam int CMAX = (2 ** CW) - 1;

    typedef logic [AW+CW+2:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    bit m_busy;
    int m_acc;
    int m_cnt;
    bit m_sat;

    product_accumulator_if #(.ACC_W(AW), .CNT_W(CW)) bus ();

    product_accumulator #(.ACC_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t snap();
        return {bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count, bus.out_sat};
    endfunction

    function automatic vec_t pack(input bit r, input bit v, input int sum, input int cnt, input bit s);
        return {r, v, AW'(sum), CW'(cnt), s};
    endfunction

    function automatic vec_t model_vec();
        return pack(!m_busy, m_busy, m_acc, m_cnt, m_sat);
    endfunction

    // Spec-level behaviour: integer sum clamped to the signed range, count capped.
    task automatic model_step();
        int s;
        if (!rst) begin
            m_busy = 0; m_acc = 0; m_cnt = 0; m_sat = 0;
        end else if (m_busy) begin
            if (bus.out_ready) begin
                m_busy = 0; m_acc = 0; m_cnt = 0; m_sat = 0;
            end
        end else if (bus.in_valid) begin
            if (bus.clr) begin
                m_acc = 0; m_cnt = 0; m_sat = 0;
            end
            s = m_acc + int'($signed(bus.in_product));
            if (s > MAXV) begin
                s = MAXV; m_sat = 1;
            end else if (s < MINV) begin
                s = MINV; m_sat = 1;
            end
            m_acc = s;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (bus.in_last) m_busy = 1;
        end else if (bus.clr) begin
            m_acc = 0; m_cnt = 0; m_sat = 0;
        end
    endtask

    task automatic drive(input bit v, input int p, input bit last, input bit c, input bit ordy);
        bus.in_valid   = v;
        bus.in_product = 15'(p);
        bus.in_last    = last;
        bus.clr        = c;
        bus.out_ready  = ordy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 123, 1, 0, 0);
        drive(1, 456, 1, 1, 1);
        total++;
        if (snap() !== pack(1, 0, 0, 0, 0)) begin
            bad++; $display("FAIL reset_state got=%h want=%h", snap(), pack(1, 0, 0, 0, 0));
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        total++;
        if (snap() !== pack(1, 0, 0, 0, 0)) begin
            bad++; $display("FAIL reset_release got=%h want=%h", snap(), pack(1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_basic();
        drive(1, 100, 0, 0, 1);
        total++;
        if (snap() !== pack(1, 0, 100, 1, 0)) begin
            bad++; $display("FAIL basic_first got=%h want=%h", snap(), pack(1, 0, 100, 1, 0));
        end
        drive(1, -30, 0, 0, 1);
        drive(1, 7, 1, 0, 1);
        total++;
        if (snap() !== pack(0, 1, 77, 3, 0)) begin
            bad++; $display("FAIL basic_result got=%h want=%h", snap(), pack(0, 1, 77, 3, 0));
        end
        drive(0, 0, 0, 0, 1);
        total++;
        if (snap() !== pack(1, 0, 0, 0, 0)) begin
            bad++; $display("FAIL basic_return got=%h want=%h", snap(), pack(1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_saturation();
        drive(1, 16383, 0, 0, 0);
        drive(1, 16383, 0, 0, 0);
        total++;
        if (snap() !== pack(1, 0, 32766, 2, 0)) begin
            bad++; $display("FAIL sat_pre got=%h want=%h", snap(), pack(1, 0, 32766, 2, 0));
        end
        drive(1, 16383, 1, 0, 0);
        total++;
        if (snap() !== pack(0, 1, 32767, 3, 1)) begin
            bad++; $display("FAIL sat_pos got=%h want=%h", snap(), pack(0, 1, 32767, 3, 1));
        end
        drive(0, 0, 0, 0, 1);
        drive(1, -5, 1, 0, 0);
        total++;
        if (snap() !== pack(0, 1, -5, 1, 0)) begin
            bad++; $display("FAIL sat_cleared got=%h want=%h", snap(), pack(0, 1, -5, 1, 0));
        end
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, -16384, i == 2, 0, 0);
        total++;
        if (snap() !== pack(0, 1, -32768, 3, 1)) begin
            bad++; $display("FAIL sat_neg got=%h want=%h", snap(), pack(0, 1, -32768, 3, 1));
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        drive(1, 42, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 9, 1, 0, 0);
            total++;
            if (snap() !== pack(0, 1, 42, 1, 0)) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, snap(), pack(0, 1, 42, 1, 0));
            end
        end
        drive(1, 9, 1, 0, 1);
        total++;
        if (snap() !== pack(1, 0, 0, 0, 0)) begin
            bad++; $display("FAIL bp_handshake got=%h want=%h", snap(), pack(1, 0, 0, 0, 0));
        end
        drive(1, 9, 1, 0, 0);
        total++;
        if (snap() !== pack(0, 1, 9, 1, 0)) begin
            bad++; $display("FAIL bp_next got=%h want=%h", snap(), pack(0, 1, 9, 1, 0));
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_clr();
        drive(1, 50, 0, 0, 0);
        drive(1, 8, 1, 1, 0);
        total++;
        if (snap() !== pack(0, 1, 8, 1, 0)) begin
            bad++; $display("FAIL clr_collide got=%h want=%h", snap(), pack(0, 1, 8, 1, 0));
        end
        drive(0, 0, 0, 1, 0);
        total++;
        if (snap() !== pack(0, 1, 8, 1, 0)) begin
            bad++; $display("FAIL clr_in_out got=%h want=%h", snap(), pack(0, 1, 8, 1, 0));
        end
        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) drive(1, 16383, 0, 0, 0);
        total++;
        if (snap() !== pack(1, 0, 32767, 3, 1)) begin
            bad++; $display("FAIL clr_presat got=%h want=%h", snap(), pack(1, 0, 32767, 3, 1));
        end
        drive(0, 0, 0, 1, 0);
        total++;
        if (snap() !== pack(1, 0, 0, 0, 0)) begin
            bad++; $display("FAIL clr_idle got=%h want=%h", snap(), pack(1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_count_hold();
        for (int i = 0; i < 20; i++) drive(1, 1, i == 19, 0, 0);
        total++;
        if (snap() !== pack(0, 1, 20, CMAX, 0)) begin
            bad++; $display("FAIL count_hold got=%h want=%h", snap(), pack(0, 1, 20, CMAX, 0));
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        drive(1, 20, 0, 0, 0);
        drive(1, 30, 0, 0, 0);
        rst = 1'b0;
        drive(1, 77, 1, 1, 1);
        rst = 1'b1;
        total++;
        if (snap() !== pack(1, 0, 0, 0, 0)) begin
            bad++; $display("FAIL rst_mid got=%h want=%h", snap(), pack(1, 0, 0, 0, 0));
        end
        drive(1, 5, 1, 0, 0);
        total++;
        if (snap() !== pack(0, 1, 5, 1, 0)) begin
            bad++; $display("FAIL rst_after got=%h want=%h", snap(), pack(0, 1, 5, 1, 0));
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        total++;
        if (snap() !== pack(1, 0, 0, 0, 0)) begin
            bad++; $display("FAIL rst_in_out got=%h want=%h", snap(), pack(1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        int p;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 80) != 0);
            case ($urandom_range(0, 3))
                0:       p = ($urandom_range(0, 1) != 0) ? 16383 : -16384;
                1:       p = int'($urandom_range(0, 32767)) - 16384;
                default: p = int'($urandom_range(0, 400)) - 200;
            endcase
            drive($urandom_range(0, 3) != 0, p, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 1) != 0);
            total++;
            if (snap() !== model_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, snap(), model_vec());
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        m_busy = 0; m_acc = 0; m_cnt = 0; m_sat = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_clr();
        test_count_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter: ACC_W, default 24, width of the signed accumulator and of out_sum (legal range 16..32).
REQ-002 Parameter: CNT_W, default 8, width of the term counter and of out_count.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  a product beat is offered this cycle.
REQ-006 in_ready  output  1  the block accepts a beat this cycle.
REQ-007 in_product  input  15  signed two's-complement product, in the sign-extended 15-bit format produced by the multiplier stage.
REQ-008 in_last  input  1  qualifies the accepted beat as the final term of the current sum.
REQ-009 clr  input  1  discards the running sum and count while accumulating.
REQ-010 out_valid  output  1  the result registers hold a completed sum.
REQ-011 out_ready  input  1  the consumer takes the result this cycle.
REQ-012 out_sum  output  ACC_W  signed accumulated result.
REQ-013 out_count  output  CNT_W  number of terms accepted into out_sum.
REQ-014 out_sat  output  1  sticky flag: the sum saturated at least once since the last clear.

Function
REQ-015 The block SHALL implement a two-state FSM: ACCUM and OUT.
REQ-016 In ACCUM:
- in_ready SHALL be 1.
- out_valid SHALL be 0.
REQ-017 In OUT:
- in_ready SHALL be 0.
- out_valid SHALL be 1.
- out_sum, out_count and out_sat SHALL be stable until the handshake completes.
REQ-018 A beat SHALL be accepted only on a cycle where in_valid=1 and in_ready=1. in_product, in_last and in_valid SHALL be ignored on all other cycles.
REQ-019 On an accepted beat, the next accumulator value SHALL be sat(acc + sign_extend(in_product to ACC_W+1 bits)).
- The sum is computed at ACC_W+1 bits.
- sat clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
REQ-020 On an accepted beat, out_count SHALL increment by 1. At 2^CNT_W-1 it SHALL hold and not wrap.
REQ-021 out_sat SHALL be set on any accepted beat whose unclamped sum lies outside the ACC_W signed range. It SHALL remain 1 until the sum is cleared.
REQ-022 An accepted beat with in_last=1 SHALL move the FSM to OUT on the next edge, with the updated sum, count and flag visible. The last beat to out_valid latency is 1 cycle.
REQ-023 In OUT with out_ready=1, on the next edge the FSM SHALL:
- return to ACCUM;
- clear acc, out_count and out_sat to 0;
- deassert out_valid.
REQ-024 In OUT with out_ready=0, the block SHALL hold all outputs indefinitely (backpressure).
REQ-025 clr=1 in ACCUM without an accepted beat SHALL zero acc, out_count and out_sat on the next edge.
REQ-026 clr=1 with an accepted beat in the same cycle SHALL result in acc=sign_extend(in_product), out_count=1 and out_sat=0. in_last SHALL still be honoured.
REQ-027 clr SHALL be ignored in OUT.
REQ-028 out_sum SHALL be driven directly from the accumulator register. There SHALL be no combinational path from in_* to out_*.
REQ-029 No combinational path SHALL exist from out_ready to in_ready.
REQ-030 A new term sequence SHALL be accepted at the earliest on the cycle after the out handshake. Minimum spacing between results is therefore (terms + 1) cycles.

Reset
REQ-031 While rst=0 at a rising edge, the block SHALL enter ACCUM with acc=0, out_count=0 and out_sat=0.
REQ-032 During reset, the outputs SHALL take the values in_ready=1, out_valid=0, out_sum=0, out_count=0 and out_sat=0.
REQ-033 Reset asserted in OUT or mid-sequence SHALL discard the pending result; no out_valid SHALL follow it.
REQ-034 Reset SHALL take priority over clr, accepted beats and out_ready on the same edge.

Verification
REQ-035 Basic sum: beats 100, -30, 7 (last on the third), out_ready=1 -> one cycle later out_valid=1, out_sum=77, out_count=3, out_sat=0. The next cycle returns to ACCUM with zeros.
REQ-036 Saturation (ACC_W=16): beats 16383, 16383, 16383 (last) -> out_sum=32767, out_sat=1, out_count=3. A second sequence of -5 (last) -> out_sum=-5, out_sat=0.
REQ-037 Negative clamp (ACC_W=16): beats -16384 x3 (last) -> out_sum=-32768, out_sat=1.
REQ-038 Backpressure: result 42 is held with out_ready=0 for 10 cycles while in_valid=1 offers 9 -> in_ready=0 throughout, out_sum stays 42, and the 9 is accepted only after the handshake.
REQ-039 clr collision: accept 50, then clr=1 together with beat 8 (last) -> out_sum=8, out_count=1. Then clr=1 in OUT -> no effect.
REQ-040 Reset mid-operation: accept 20, 30, then rst=0 for one cycle, then beat 5 (last) -> out_sum=5 and out_count=1. No result is emitted for the aborted sequence.
